// File: rtl/mux_sel_ctrl.sv
// Select-line generator for a downstream 2:1 mux: a debounced push-button toggles s in
// manual mode, and a free-running period counter toggles it in auto mode.
module mux_sel_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int PERIOD     = 8,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic auto_en,
   output logic s,
   output logic s_chg,
   output logic btn_db
);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_next;
   logic [CNT_W-1:0] dc, dc_next;
   logic [CNT_W-1:0] pc, pc_next;
   logic             sync_q1, sync_q2;
   logic             press_ev, pc_wrap, toggle;

   // Two-flop synchroniser; only sync_q2 is allowed to reach the debounce FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         dc     <= '0;
         pc     <= '0;
         s      <= 1'b0;
         s_chg  <= 1'b0;
         btn_db <= 1'b0;
      end else begin
         state  <= state_next;
         dc     <= dc_next;
         pc     <= pc_next;
         s      <= s ^ toggle;
         s_chg  <= toggle;
         btn_db <= (state_next == HELD) || (state_next == REL_CHK);
      end
   end

   // A level change is accepted only after DEB_CYCLES consecutive agreeing samples
   always_comb begin
      state_next = state;
      dc_next    = dc;
      press_ev   = 1'b0;
      case (state)
         IDLE: begin
            if (sync_q2) begin
               if (DEB_CYCLES == 1) begin
                  state_next = HELD;
                  press_ev   = 1'b1;
               end else begin
                  state_next = PRESS_CHK;
                  dc_next    = CNT_ONE;
               end
            end
         end
         PRESS_CHK: begin
            if (!sync_q2) begin
               state_next = IDLE;
               dc_next    = '0;
            end else if (dc == DEB_LAST) begin
               state_next = HELD;
               dc_next    = '0;
               press_ev   = 1'b1;
            end else begin
               dc_next = dc + CNT_ONE;
            end
         end
         HELD: begin
            if (!sync_q2) begin
               if (DEB_CYCLES == 1) begin
                  state_next = IDLE;
               end else begin
                  state_next = REL_CHK;
                  dc_next    = CNT_ONE;
               end
            end
         end
         REL_CHK: begin
            if (sync_q2) begin
               state_next = HELD;
               dc_next    = '0;
            end else if (dc == DEB_LAST) begin
               state_next = IDLE;
               dc_next    = '0;
            end else begin
               dc_next = dc + CNT_ONE;
            end
         end
         default: begin
            state_next = IDLE;
            dc_next    = '0;
         end
      endcase
   end

   // In auto mode button presses are ignored, so at most one toggle source is live
   always_comb begin
      pc_wrap = auto_en && (pc == PER_LAST);
      pc_next = '0;
      if (auto_en && !pc_wrap) begin
         pc_next = pc + CNT_ONE;
      end
      toggle = auto_en ? pc_wrap : press_ev;
   end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
- Generates the select line `s` for the downstream 2:1 mux stage, which computes y = (~s & a) | (s & b).
- Two modes:
  - Manual: a raw push-button is synchronised and debounced, and each debounced press toggles `s`.
  - Auto: `s` toggles on its own every PERIOD cycles.
- Sits directly upstream of the mux. It is the only sequential element in the select path.

Parameters:
- DEB_CYCLES, 4: consecutive synchronised samples required to accept a press or a release. Legal range 1..2^CNT_W-1.
- PERIOD, 8: auto-mode toggle interval in clk cycles. Legal range 2..2^CNT_W-1.
- CNT_W, 16: width of the debounce counter and the period counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
- auto_en  input  1  synchronous mode select; 1 = auto toggle, 0 = manual (button) toggle.
- s  output  1  registered select to the 2:1 mux; 0 selects a, 1 selects b.
- s_chg  output  1  registered one-cycle pulse, high in the cycle immediately after each edge at which `s` toggled.
- btn_db  output  1  registered debounced button level.

Behaviour:

Reset (rst_n = 0, asynchronous):
- s = 0, s_chg = 0, btn_db = 0.
- FSM = IDLE, both counters = 0, both synchroniser flops = 0.
- Deasserting reset mid-debounce or mid-period discards all progress.
- First active edge after release behaves as from a clean IDLE.

Synchroniser:
- Two-flop chain on btn. Output `sync` is valid 2 edges after btn is sampled.
- Only `sync` feeds the FSM.

Debounce FSM (4 states), debounce counter `dc`:
- IDLE (btn_db = 0):
  - sync = 1 with DEB_CYCLES = 1 → HELD and raise a press event.
  - sync = 1 otherwise → PRESS_CHK with dc = 1.
  - sync = 0 → stay.
- PRESS_CHK:
  - sync = 0 → IDLE, dc = 0.
  - sync = 1 and dc = DEB_CYCLES-1 → HELD, btn_db = 1, press event.
  - sync = 1 otherwise → dc + 1.
- HELD (btn_db = 1):
  - sync = 0 → REL_CHK with dc = 1, or → IDLE directly if DEB_CYCLES = 1.
  - sync = 1 → stay.
- REL_CHK:
  - sync = 1 → HELD, dc = 0.
  - sync = 0 and dc = DEB_CYCLES-1 → IDLE, btn_db = 0.
  - sync = 0 otherwise → dc + 1.
  - Release never generates an event.

Press latency:
- First edge sampling btn = 1 is edge 1. The toggle occurs at edge 2 + DEB_CYCLES if btn stays high throughout.
- Default: toggle at edge 6.
- A pulse yielding fewer than DEB_CYCLES consecutive sync = 1 samples produces no toggle and leaves btn_db = 0.

Manual toggle:
- A press event with auto_en = 0 sets s <= ~s and s_chg <= 1 on the same edge.

Auto mode, period counter `pc`:
- While auto_en = 1: pc counts 0..PERIOD-1.
- At pc = PERIOD-1: s <= ~s, s_chg <= 1, pc <= 0.
- While auto_en = 0: pc is held at 0.
- First toggle occurs PERIOD edges after the first edge that samples auto_en = 1.
- Dropping auto_en mid-count clears pc; `s` keeps its value.

Simultaneous events:
- A press event while auto_en = 1 is ignored by the select logic.
- The debounce FSM and btn_db still update normally.
- At most one toggle per edge; `s` never double-toggles.

s_chg:
- Default value 0 every cycle unless a toggle occurred at that edge.
- Auto mode with PERIOD = 2 gives s_chg alternating 1,0,1,0.

Counter width:
- dc and pc are CNT_W bits.
- Parameters are required to fit; behaviour with out-of-range parameters is undefined.

Outputs:
- All outputs come directly from flops; no combinational path from any input to any output.

Test Plan:
1. Reset check: assert rst_n = 0 mid-run with s = 1 and PRESS_CHK active → s = 0, s_chg = 0, btn_db = 0 immediately, without waiting for a clk edge. After release, a clean press toggles at edge 6.
2. Clean press (defaults): auto_en = 0, btn = 1 held from edge 1 → s goes 0→1 at edge 6, s_chg = 1 for exactly one cycle, btn_db = 1 at edge 6. Release for 10 cycles → btn_db = 0 and s stays 1.
3. Bounce rejection: btn pattern 1,1,0,1,1,1,0 (one sample per cycle) → no toggle; s = 0, btn_db = 0 throughout. Then btn = 1 held ≥ 4 stable samples → exactly one toggle.
4. Auto mode: PERIOD = 8, auto_en = 1 from edge 1 → s toggles at edges 8, 16, 24 with s_chg pulses there. Drop auto_en at edge 20 → no toggle at 24; s stays 0 (its value after edge 16).
5. Conflict: auto_en = 1 while a debounced press completes → s changes only on period boundaries, while btn_db still rises. With PERIOD = 2 → s_chg alternates 1,0.
6. Mux integration: drive a = 0, b = 1 into the downstream mux alongside this block → y tracks s after every toggle in both manual and auto mode.
